uart_rx: RTL
============

# uart_rx

Byte receiver for the serial link; the downstream counterpart of the UART transmitter. It consumes the same one-cycle `baud16` tick (16× bit rate) and the asynchronous serial line `RxD`. It recovers 8N1 frames, LSB first, and presents each byte on a hold-until-acknowledged interface to the I2C/command logic. It accepts frames with one or more stop bits, so the transmitter's 2-stop-bit output is received back-to-back without loss.

## Interface
- `SYNC_STAGES`, default 2: number of flip-flops in the `RxD` metastability synchronizer (≥2).
- `sysclk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; clock `sysclk`.
- `baud16` in 1: one-`sysclk`-wide enable tick at 16× baud rate.
- `RxD` in 1: asynchronous serial input, idle high.
- `RxD_data` out 8: last correctly framed byte; reset 0x00.
- `rxvalid` out 1: byte available in `RxD_data`; reset 0.
- `rxack` in 1: consumer strobe; clears `rxvalid` and `overrun`.
- `overrun` out 1: sticky; a byte completed while `rxvalid` was still set; reset 0.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low; reset 0.
- `rxbusy` out 1: high whenever the state is not IDLE; reset 0.

## Operation
- `RxD` passes through `SYNC_STAGES` flops. Call the result `rxs`. All decisions use `rxs`.
- The 4-bit tick counter `tctr` advances only on `baud16`. The 3-bit `bitctr` indexes the data bits.
- **IDLE:** on a `baud16` tick with `rxs`=0, clear `tctr` and go to START.
- **START:** when `tctr` reaches 7 on a tick (mid start bit), sample `rxs`.
  - If 1: false start; return to IDLE.
  - If 0: clear `tctr` and `bitctr`, go to DATA.
- **DATA:** on each tick where `tctr`=15 (bit centre), shift `rxs` into the MSB of shift register `sr` (right shift, LSB first) and increment `bitctr`. After bit 7, go to STOP.
- **STOP:** at `tctr`=15, sample `rxs`.
  - If 1: load `sr` into `RxD_data` and set `rxvalid`. If `rxvalid` was already 1 and `rxack` is not asserted in this cycle, also set `overrun`. New data overwrites old. Go to IDLE.
  - If 0: pulse `frame_err`, leave `RxD_data` and `rxvalid` unchanged, go to BREAK.
- **BREAK:** wait until `rxs`=1 on a tick, then go to IDLE. This prevents a held-low line from retriggering.
- `rxack` with `rxvalid`=0 has no effect.
- `rxack` in the same cycle as a load: the load wins. `rxvalid` stays 1, `overrun` is not set, and `overrun` is cleared.
- `reset` in any state returns to IDLE and clears `tctr`, `bitctr`, `sr` and all outputs. A frame in progress is discarded. The synchronizer flops reset to 1 (idle).

## Timing
- Start edge detection resolution: 1 `baud16` tick (1/16 bit).
- Sample points, in ticks after detection: start bit at 8, data bit n at 8+16(n+1), stop bit at 152.
- `rxvalid` rises one `sysclk` after the tick that samples the stop bit. The receiver is back in IDLE in that same cycle and can detect a start edge half a bit later.
- `rxvalid` falls one `sysclk` after `rxack`.
- `frame_err` is high for exactly one `sysclk`.
- Total latency from the `RxD` falling edge to `rxvalid` ≈ 9.5 bit times plus `SYNC_STAGES`+1 `sysclk`.
- Tolerates ±4% baud mismatch between transmitter and receiver.

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, STOP, BREAK);
  - `DATA_BITS`=8, `OVERSAMPLE`=16, `MID_TICK`=7, `END_TICK`=15;
  - the same constants reused by the transmitter and the `baud16` generator.
- One sub-module, `uart_sync`: a parameterised N-stage synchronizer with reset value 1. It is reused for other asynchronous inputs.

## Test plan
- **Single byte:** `baud16` every 4 `sysclk`; send 0x A5 with 1 stop bit.
  - `RxD_data`=0xA5 and `rxvalid`=1 at 152 ticks ±1 after the start edge.
  - `rxack` clears `rxvalid` next cycle.
- **Glitch:** `RxD` low for 5 ticks, then high.
  - No `rxvalid`, no `frame_err`; `rxbusy` returns to 0 at tick 8.
- **Framing error:** send 0x3C with the stop bit low, then hold low for 20 ticks.
  - One `frame_err` pulse; `rxvalid` stays 0; `RxD_data` is unchanged.
  - The next start is ignored until the line returns high.
- **Overrun:** send 0x11 then 0x22 without `rxack`.
  - `RxD_data`=0x22, `overrun`=1.
  - Repeat with `rxack` in the exact load cycle: `overrun`=0.
- **Loopback:** UART transmitter to `uart_rx`, sharing `baud16`; send 256 bytes 0x00–0xFF back-to-back with 2 stop bits.
  - All bytes are received in order with no errors.
- **Reset mid-frame:** assert `reset` during DATA bit 3.
  - All outputs are 0 next cycle; a following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame/oversampling constants
// and the baud16 divider helper used by the transmitter and tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    localparam int         DATA_BITS    = 8;
    localparam int         OVERSAMPLE   = 16;
    localparam logic [3:0] MID_TICK     = 4'd7;
    localparam logic [3:0] END_TICK     = 4'd15;
    localparam logic [2:0] LAST_BIT     = 3'(DATA_BITS - 1);
    localparam int         STOP_BITS_TX = 2;

    // sysclk cycles per baud16 tick for a given clock and baud rate
    function automatic int baud16_div(input int clk_hz, input int baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchronizer for asynchronous inputs; resets to 1 so an idle-high
// line does not produce a spurious low during reset release.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling on the baud16 tick; presents each byte
// on a hold-until-acknowledged interface with overrun and framing-error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       baud16,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       rxvalid,
    input  logic       rxack,
    output logic       overrun,
    output logic       frame_err,
    output logic       rxbusy
);

    logic                 w_rxs;
    uart_state_t          r_state;
    uart_state_t          w_next;
    logic [3:0]           r_tctr;
    logic [2:0]           r_bitctr;
    logic [DATA_BITS-1:0] r_sr;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ovr;
    logic                 r_ferr;

    logic w_tick_mid;
    logic w_tick_end;
    logic w_tclr;
    logic w_bclr;
    logic w_shift;
    logic w_load;
    logic w_ferr;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .sysclk  (sysclk),
        .reset   (reset),
        .i_async (RxD),
        .o_sync  (w_rxs)
    );

    assign w_tick_mid = baud16 && (r_tctr == MID_TICK);
    assign w_tick_end = baud16 && (r_tctr == END_TICK);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_tclr  = 1'b0;
        w_bclr  = 1'b0;
        w_shift = 1'b0;
        w_load  = 1'b0;
        w_ferr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (baud16 && !w_rxs) begin
                    w_tclr = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick_mid) begin
                    if (w_rxs) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_tclr = 1'b1;
                        w_bclr = 1'b1;
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick_end) begin
                    w_shift = 1'b1;
                    if (r_bitctr == LAST_BIT) begin
                        w_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick_end) begin
                    if (w_rxs) begin
                        w_load = 1'b1;
                        w_next = ST_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line has gone idle so a long low is not a new start
                if (baud16 && w_rxs) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_tctr   <= '0;
            r_bitctr <= '0;
            r_sr     <= '0;
        end else begin
            if (w_tclr) begin
                r_tctr <= '0;
            end else if (baud16) begin
                r_tctr <= r_tctr + 4'd1;
            end
            if (w_bclr) begin
                r_bitctr <= '0;
            end else if (w_shift) begin
                r_bitctr <= r_bitctr + 3'd1;
            end
            if (w_shift) begin
                r_sr <= {w_rxs, r_sr[DATA_BITS-1:1]};
            end
        end
    end

    // A load in the same cycle as rxack keeps rxvalid set and clears overrun
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            if (w_load) begin
                r_data  <= r_sr;
                r_valid <= 1'b1;
                r_ovr   <= rxack ? 1'b0 : (r_ovr | r_valid);
            end else if (rxack && r_valid) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
        end
    end

    assign RxD_data  = r_data;
    assign rxvalid   = r_valid;
    assign overrun   = r_ovr;
    assign frame_err = r_ferr;
    assign rxbusy    = (r_state != ST_IDLE);

endmodule
